// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: address decode constants and STATUS word packing for dmem_mmio.
package dmem_mmio_pkg;
    localparam int MMIO_BIT = 31;
    localparam logic [2:0] OFF_CYCLE   = 3'd0;
    localparam logic [2:0] OFF_TXDATA  = 3'd1;
    localparam logic [2:0] OFF_STATUS  = 3'd2;
    localparam logic [2:0] OFF_SCRATCH = 3'd3;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_CNT   = 8;

    function automatic logic [63:0] status_word(input logic empty, input logic full,
                                                input logic ovf, input logic [3:0] cnt);
        logic [63:0] w;
        w = '0;
        w[ST_EMPTY] = empty;
        w[ST_FULL] = full;
        w[ST_OVF] = ovf;
        w[ST_CNT +: 4] = cnt;
        return w;
    endfunction
endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: MEM-stage data bus plus the TX byte stream of dmem_mmio.
interface dmem_mmio_if;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (output addr, wr_en, wdata, wmask, tx_ready, input rdata, tx_valid, tx_data);
    modport slave  (input addr, wr_en, wdata, wmask, tx_ready, output rdata, tx_valid, tx_data);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no fall-through; a push into a full FIFO succeeds when a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-maskable 64-bit data RAM with an MMIO window (CYCLE, TXDATA, STATUS, SCRATCH).
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        nrst,
    dmem_mmio_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]   ram_q [DEPTH_WORDS];
    logic [63:0]   cycle_q, scratch_q, scratch_d, mmio_rd;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] idx;
    logic [2:0]    off;
    logic          wr_ram, wr_mmio, push, pop, full, empty;
    logic [CW-1:0] count;
    logic          unused_addr;

    assign idx         = bus.addr[3 +: AW];
    assign off         = bus.addr[5:3];
    assign wr_ram      = nrst && bus.wr_en && !bus.addr[MMIO_BIT];
    assign wr_mmio     = bus.wr_en && bus.addr[MMIO_BIT];
    assign push        = wr_mmio && off == OFF_TXDATA && bus.wmask[0];
    assign pop         = bus.tx_valid && bus.tx_ready;
    assign bus.tx_valid = !empty;
    assign unused_addr = ^{bus.addr[30:6], bus.addr[2:0]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push),
        .din_i   (bus.wdata[7:0]),
        .pop_i   (pop),
        .dout_o  (bus.tx_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A rejected push sets overflow; that beats a clear in the same cycle.
    always_comb begin
        scratch_d = scratch_q;
        for (int b = 0; b < 8; b++)
            if (wr_mmio && off == OFF_SCRATCH && bus.wmask[b]) scratch_d[8*b +: 8] = bus.wdata[8*b +: 8];
        ovf_d = (push && full && !pop) ? 1'b1 :
                (wr_mmio && off == OFF_STATUS && bus.wmask[0] && bus.wdata[ST_OVF]) ? 1'b0 : ovf_q;
    end

    assign mmio_rd = (off == OFF_CYCLE)   ? cycle_q :
                     (off == OFF_STATUS)  ? status_word(empty, full, ovf_q, 4'(count)) :
                     (off == OFF_SCRATCH) ? scratch_q : '0;
    assign bus.rdata = !nrst ? '0 : bus.addr[MMIO_BIT] ? mmio_rd : ram_q[idx];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cycle_q   <= cycle_q + 64'd1;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ram)
            for (int b = 0; b < 8; b++)
                if (bus.wmask[b]) ram_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
endmodule
